schedule_tracker: RTL and testbench
===================================

# schedule_tracker

Receiving-end companion to the `Schedule` sequencer in the simulation pipeline. It samples the 3-bit `state` code that `Schedule` broadcasts and checks the sequence against the legal transition order. For each working state it issues a one-hot start pulse to the matching datapath stage, then returns a registered acknowledge once that stage reports done. It also latches the seed at LOAD_SEED, counts completed rounds, and raises sticky protocol errors for illegal transitions, overruns and stage timeouts.

## Interface
- `SEED_W`, 8, seed width; matches `seed_ID`.
- `ROUND_W`, 16, width of the completed-round counter.
- `TIMEOUT`, 255, maximum cycles from `stage_start` to `stage_done` (1..2^16-1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 clears all state.
- `state`  in  3  schedule code from `Schedule`.
- `seed_ID`  in  SEED_W  seed presented by the top level.
- `stage_done`  in  1  single-cycle done pulse from the active stage.
- `stage_start`  out  5  one-hot start pulse: bit0 LOAD_SEED, bit1 GEN_RAND, bit2 EVOLVE, bit3 WRITE_OUT, bit4 reserved (always 0).
- `stage_ack`  out  1  level; current stage has completed.
- `busy`  out  1  a stage is started and not yet done.
- `seed_latched`  out  SEED_W  seed captured on LOAD_SEED entry.
- `round_cnt`  out  ROUND_W  number of DONE entries, modulo 2^ROUND_W.
- `err_illegal`, `err_overrun`, `err_timeout`  out  1 each  sticky error flags.

## Operation
- State codes:
  - 000 IDLE
  - 001 LOAD_SEED
  - 010 GEN_RAND
  - 011 EVOLVE
  - 100 WRITE_OUT
  - 101 DONE
  - 110 and 111 are always illegal.
- Legal transitions: 000→001; 001→010; 010→011; 011→100; 100→010 (next site) or 100→101; 101→000. Any other change sets `err_illegal`.
- Internal register `state_q` holds the last sampled code; its reset value is 000.
- A transition is detected when `state != state_q`. On every transition, `state_q` takes the new code. The tracker always resynchronises to the new code, whether or not the transition was legal.
- Legal transition into 001..100:
  - pulse the matching `stage_start` bit;
  - set `busy`;
  - clear `stage_ack`;
  - load the watchdog with TIMEOUT.
- Illegal transition: no start pulse; `busy` and `stage_ack` cleared.
- Entry to IDLE or DONE: no start pulse; `busy` cleared; `stage_ack` cleared.
- Entry to DONE (legal only): `round_cnt` += 1, wrapping to 0.
- Entry to LOAD_SEED (legal only): `seed_latched` ← `seed_ID`, sampled in the detection cycle.
- `stage_done` while `busy`: clear `busy`, set `stage_ack`; `stage_ack` then holds until the next transition.
- `stage_done` while not `busy`: ignored, no error.
- Overrun: a transition while `busy`, with no `stage_done` in the same cycle, sets `err_overrun`. The new stage is still started if the transition is legal.
- Watchdog: decrements each cycle while `busy`. On reaching 0 it sets `err_timeout` and clears `busy`; `stage_ack` stays 0.
- Error flags clear only on reset.

## Timing
- All outputs are registered. Reset values:
  - `stage_start` = 0, `stage_ack` = 0, `busy` = 0;
  - `seed_latched` = 0, `round_cnt` = 0;
  - all error flags = 0.
- Start latency: a new `state` sampled at edge N gives `stage_start` high for exactly one cycle after edge N+1, with `busy` high from the same edge.
- Ack latency: `stage_done` sampled at edge M gives `stage_ack` = 1 and `busy` = 0 after edge M+1.
- Same cycle `stage_done` and transition: the done is credited to the old stage (no overrun). The new transition then governs, so `stage_ack` ends at 0 if a new stage starts.
- Back-to-back transitions on consecutive cycles: each is evaluated independently, giving one start pulse per legal working-state entry.
- Reset released while `state` ≠ 000: treated as a transition from IDLE. 001 is legal; any other value sets `err_illegal`.
- Reset asserted mid-stage: outputs clear asynchronously and no pulse completes.
- Watchdog: with TIMEOUT = T and no done, `err_timeout` rises T cycles after the `stage_start` pulse. A `stage_done` in that same cycle wins: no error.

## Test plan
- Full legal round: `seed_ID` = 8'h5A; drive 000→001→010→011→100→101→000, returning `stage_done` 3 cycles after each start → start pulses 01,02,04,08 (hex) in order; `seed_latched` = 5A; `round_cnt` = 1; no errors.
- Multi-site loop: 001→010→011→100→010→011→100→101 → GEN_RAND and EVOLVE each pulse twice; `round_cnt` increments once.
- Illegal codes: jump 010→100, then drive 110 → `err_illegal` = 1 after the first jump; no `stage_start` for either; flag still 1 after 20 more cycles.
- Overrun vs. simultaneous done: change state with no done → `err_overrun` = 1. Fresh reset, then change state in the same cycle as `stage_done` → `err_overrun` stays 0.
- Timeout: TIMEOUT = 4, enter GEN_RAND, never send done → `err_timeout` = 1 exactly 4 cycles after the start pulse; `busy` = 0; `stage_ack` = 0.
- Reset: `reset` = 0 mid-EVOLVE → all outputs 0 immediately. Release with `state` = 011 → `err_illegal` = 1 and no start pulse.

Source files
------------

// File: rtl/schedule_tracker.sv
// Receiving-end tracker for the Schedule sequencer: checks the broadcast state
// sequence, pulses stage starts, returns acks and flags protocol errors.
module schedule_tracker #(
    parameter int SEED_W  = 8,
    parameter int ROUND_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         state,
    input  logic [SEED_W-1:0]  seed_ID,
    input  logic               stage_done,
    output logic [4:0]         stage_start,
    output logic               stage_ack,
    output logic               busy,
    output logic [SEED_W-1:0]  seed_latched,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               err_illegal,
    output logic               err_overrun,
    output logic               err_timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_SEED = 3'd1;
    localparam logic [2:0] ST_GEN_RAND  = 3'd2;
    localparam logic [2:0] ST_EVOLVE    = 3'd3;
    localparam logic [2:0] ST_WRITE_OUT = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [15:0]      WDOG_LOAD = 16'(TIMEOUT);
    localparam logic [ROUND_W-1:0] ROUND_ONE = {{(ROUND_W-1){1'b0}}, 1'b1};

    logic [2:0]         state_in_q, state_in_d;
    logic               done_in_q, done_in_d;
    logic [2:0]         state_q, state_d;
    logic [4:0]         start_q, start_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [15:0]        wdog_q, wdog_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               err_illegal_q, err_illegal_d;
    logic               err_overrun_q, err_overrun_d;
    logic               err_timeout_q, err_timeout_d;

    logic               transition;
    logic               legal;

    assign transition = (state_in_q != state_q);

    always_comb begin
        legal = 1'b0;
        case ({state_q, state_in_q})
            {ST_IDLE,      ST_LOAD_SEED}: legal = 1'b1;
            {ST_LOAD_SEED, ST_GEN_RAND }: legal = 1'b1;
            {ST_GEN_RAND,  ST_EVOLVE   }: legal = 1'b1;
            {ST_EVOLVE,    ST_WRITE_OUT}: legal = 1'b1;
            {ST_WRITE_OUT, ST_GEN_RAND }: legal = 1'b1;
            {ST_WRITE_OUT, ST_DONE     }: legal = 1'b1;
            {ST_DONE,      ST_IDLE     }: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
    end

    // A done arriving with a transition is credited to the old stage first;
    // the transition then overrides busy/ack for the new stage.
    always_comb begin
        state_in_d    = state;
        done_in_d     = stage_done;
        state_d       = state_q;
        start_d       = 5'd0;
        ack_d         = ack_q;
        busy_d        = busy_q;
        wdog_d        = wdog_q;
        seed_d        = seed_q;
        round_d       = round_q;
        err_illegal_d = err_illegal_q;
        err_overrun_d = err_overrun_q;
        err_timeout_d = err_timeout_q;

        if (busy_q) begin
            if (done_in_q) begin
                busy_d = 1'b0;
                ack_d  = 1'b1;
            end else begin
                if (wdog_q <= 16'd1) begin
                    err_timeout_d = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    wdog_d = wdog_q - 16'd1;
                end
                if (transition) begin
                    err_overrun_d = 1'b1;
                end
            end
        end

        if (transition) begin
            state_d = state_in_q;
            busy_d  = 1'b0;
            ack_d   = 1'b0;
            if (!legal) begin
                err_illegal_d = 1'b1;
            end else begin
                case (state_in_q)
                    ST_LOAD_SEED: begin
                        start_d = 5'b00001;
                        seed_d  = seed_ID;
                    end
                    ST_GEN_RAND:  start_d = 5'b00010;
                    ST_EVOLVE:    start_d = 5'b00100;
                    ST_WRITE_OUT: start_d = 5'b01000;
                    ST_DONE:      round_d = round_q + ROUND_ONE;
                    default:      start_d = 5'b00000;
                endcase
                if (start_d != 5'b00000) begin
                    busy_d = 1'b1;
                    wdog_d = WDOG_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_in_q    <= ST_IDLE;
            done_in_q     <= 1'b0;
            state_q       <= ST_IDLE;
            start_q       <= 5'd0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            wdog_q        <= 16'd0;
            seed_q        <= '0;
            round_q       <= '0;
            err_illegal_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_in_q    <= state_in_d;
            done_in_q     <= done_in_d;
            state_q       <= state_d;
            start_q       <= start_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            wdog_q        <= wdog_d;
            seed_q        <= seed_d;
            round_q       <= round_d;
            err_illegal_q <= err_illegal_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign stage_start  = start_q;
    assign stage_ack    = ack_q;
    assign busy         = busy_q;
    assign seed_latched = seed_q;
    assign round_cnt    = round_q;
    assign err_illegal  = err_illegal_q;
    assign err_overrun  = err_overrun_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_schedule_tracker.sv
// Directed scenarios plus a randomized phase, all checked every cycle against
// a cycle-level behavioural model of the schedule tracker.
module tb_schedule_tracker;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  state;
    logic [7:0]  seed_ID;
    logic        stage_done;
    logic [4:0]  stage_start;
    logic        stage_ack;
    logic        busy;
    logic [7:0]  seed_latched;
    logic [15:0] round_cnt;
    logic        err_illegal;
    logic        err_overrun;
    logic        err_timeout;

    schedule_tracker #(.SEED_W(8), .ROUND_W(16), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .state(state), .seed_ID(seed_ID),
        .stage_done(stage_done), .stage_start(stage_start), .stage_ack(stage_ack),
        .busy(busy), .seed_latched(seed_latched), .round_cnt(round_cnt),
        .err_illegal(err_illegal), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cur_state, cur_done, cur_seed;
    int p_state, p_done, m_state, m_elapsed, m_start, m_seed, m_round;
    bit m_busy, m_ack, m_err_i, m_err_o, m_err_t;
    int pulse_cnt [5];
    int pulse_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_move(input int from, input int to);
        return (from == 0 && to == 1) || (from == 1 && to == 2) || (from == 2 && to == 3) ||
               (from == 3 && to == 4) || (from == 4 && (to == 2 || to == 5)) ||
               (from == 5 && to == 0);
    endfunction

    task automatic model_reset();
        p_state = 0; p_done = 0; m_state = 0; m_elapsed = 0; m_start = 0;
        m_seed = 0; m_round = 0; m_busy = 0; m_ack = 0;
        m_err_i = 0; m_err_o = 0; m_err_t = 0;
        foreach (pulse_cnt[i]) pulse_cnt[i] = 0;
        pulse_log.delete();
    endtask

    // One clock edge of the tracker as described by its rules; the inputs the
    // tracker sees now are those that were present on the previous edge.
    task automatic model_edge();
        bit trans;
        trans = (p_state != m_state);
        m_start = 0;
        if (m_busy) begin
            if (p_done != 0) begin
                m_busy = 0;
                m_ack  = 1;
            end else begin
                m_elapsed++;
                if (m_elapsed >= T) begin
                    m_err_t = 1;
                    m_busy  = 0;
                end
                if (trans) m_err_o = 1;
            end
        end
        if (trans) begin
            m_busy = 0;
            m_ack  = 0;
            if (!legal_move(m_state, p_state)) begin
                m_err_i = 1;
            end else if (p_state >= 1 && p_state <= 4) begin
                m_start   = 1 << (p_state - 1);
                m_busy    = 1;
                m_elapsed = 0;
                if (p_state == 1) m_seed = cur_seed;
            end else if (p_state == 5) begin
                m_round = (m_round + 1) % 65536;
            end
            m_state = p_state;
        end
        p_state = cur_state;
        p_done  = cur_done;
    endtask

    task automatic check_output();
        chk("stage_start", 32'(stage_start), 32'(m_start));
        chk("stage_ack", 32'(stage_ack), 32'(m_ack));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("seed_latched", 32'(seed_latched), 32'(m_seed));
        chk("round_cnt", 32'(round_cnt), 32'(m_round));
        chk("err_illegal", 32'(err_illegal), 32'(m_err_i));
        chk("err_overrun", 32'(err_overrun), 32'(m_err_o));
        chk("err_timeout", 32'(err_timeout), 32'(m_err_t));
    endtask

    task automatic apply_stimulus(input int st, input int dn);
        cur_state  = st;
        cur_done   = dn;
        state      = 3'(st);
        stage_done = dn[0];
        seed_ID    = 8'(cur_seed);
        @(posedge clk);
        model_edge();
        #2;
        check_output();
        for (int b = 0; b < 5; b++) if (stage_start[b]) pulse_cnt[b]++;
        if (stage_start != 5'd0) pulse_log.push_back(int'(stage_start));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; state = 3'd0; stage_done = 1'b0;
        cur_state = 0; cur_done = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_stage(input int code, input int gap);
        apply_stimulus(code, 0);
        apply_stimulus(code, 0);
        chk("start_onehot", 32'(stage_start), 32'(1 << (code - 1)));
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (gap - 1) apply_stimulus(code, 0);
        apply_stimulus(code, 1);
        apply_stimulus(code, 0);
        chk("ack_after_done", 32'(stage_ack), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int cur, nxt, hold;
        cur_seed = 8'h5A;
        seed_ID  = 8'h5A;
        do_reset();
        check_output();
        chk("reset_start", 32'(stage_start), 32'd0);
        chk("reset_round", 32'(round_cnt), 32'd0);

        // Full legal round
        for (int c = 1; c <= 4; c++) run_stage(c, 3);
        repeat (2) apply_stimulus(5, 0);
        repeat (2) apply_stimulus(0, 0);
        chk("round_pulse_count", 32'(pulse_log.size()), 32'd4);
        for (int i = 0; i < pulse_log.size() && i < 4; i++)
            chk("round_pulse_order", 32'(pulse_log[i]), 32'(1 << i));
        chk("round_seed", 32'(seed_latched), 32'h5A);
        chk("round_cnt_one", 32'(round_cnt), 32'd1);
        chk("round_no_err", 32'({err_illegal, err_overrun, err_timeout}), 32'd0);

        // Multi-site loop
        do_reset();
        run_stage(1, 2);
        for (int s = 0; s < 2; s++) for (int c = 2; c <= 4; c++) run_stage(c, 2);
        repeat (2) apply_stimulus(5, 0);
        chk("loop_gen_pulses", 32'(pulse_cnt[1]), 32'd2);
        chk("loop_evolve_pulses", 32'(pulse_cnt[2]), 32'd2);
        chk("loop_round", 32'(round_cnt), 32'd1);

        // Illegal codes
        do_reset();
        run_stage(1, 2);
        run_stage(2, 2);
        repeat (2) apply_stimulus(4, 0);
        chk("illegal_flag", 32'(err_illegal), 32'd1);
        chk("illegal_no_start", 32'(stage_start), 32'd0);
        repeat (2) apply_stimulus(6, 0);
        chk("illegal6_no_start", 32'(stage_start), 32'd0);
        repeat (20) apply_stimulus(6, 0);
        chk("illegal_sticky", 32'(err_illegal), 32'd1);

        // Overrun versus simultaneous done
        do_reset();
        repeat (2) apply_stimulus(1, 0);
        repeat (2) apply_stimulus(2, 0);
        chk("overrun_flag", 32'(err_overrun), 32'd1);
        chk("overrun_still_starts", 32'(stage_start), 32'd2);
        do_reset();
        repeat (3) apply_stimulus(1, 0);
        apply_stimulus(2, 1);
        apply_stimulus(2, 0);
        chk("simul_no_overrun", 32'(err_overrun), 32'd0);
        chk("simul_start", 32'(stage_start), 32'd2);
        chk("simul_ack", 32'(stage_ack), 32'd0);

        // Timeout
        do_reset();
        run_stage(1, 2);
        repeat (2) apply_stimulus(2, 0);
        chk("to_start", 32'(stage_start), 32'd2);
        for (int k = 1; k < T; k++) begin
            apply_stimulus(2, 0);
            chk("to_not_yet", 32'(err_timeout), 32'd0);
        end
        apply_stimulus(2, 0);
        chk("to_flag", 32'(err_timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_ack", 32'(stage_ack), 32'd0);

        // Reset mid-EVOLVE, release with state = EVOLVE
        do_reset();
        run_stage(1, 1);
        run_stage(2, 1);
        repeat (2) apply_stimulus(3, 0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_clear", 32'({stage_start, stage_ack, busy, err_illegal, err_overrun, err_timeout}), 32'd0);
        chk("async_seed_round", 32'({seed_latched, round_cnt}), 32'd0);
        model_reset();
        state = 3'd3; cur_state = 3;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) apply_stimulus(3, 0);
        chk("release_illegal", 32'(err_illegal), 32'd1);
        chk("release_no_start", 32'(stage_start), 32'd0);

        // Randomized sequences, mostly legal with occasional arbitrary codes
        do_reset();
        cur = 0;
        for (int i = 0; i < 400; i += hold) begin
            if ($urandom_range(9) < 7) begin
                case (cur)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: nxt = 3;
                    3: nxt = 4;
                    4: nxt = ($urandom_range(1) == 0) ? 2 : 5;
                    default: nxt = 0;
                endcase
            end else begin
                nxt = int'($urandom_range(7));
            end
            if (nxt == 1) cur_seed = int'($urandom_range(255));
            hold = int'($urandom_range(5, 1));
            for (int h = 0; h < hold; h++)
                apply_stimulus(nxt, ($urandom_range(3) == 0) ? 1 : 0);
            cur = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
